rr_mux41: RTL
=============

RR_MUX41 -- requirements
Module: rr_mux41

Interface
REQ-001 Parameter WIDTH, default 8, data width of every channel and of the output.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  4  bit i set: channel i offers a word.
REQ-005 in_data  input  4*WIDTH  channel i word in bits [i*WIDTH +: WIDTH].
REQ-006 in_ready  output  4  bit i set: channel i word is taken at this edge; combinational.
REQ-007 out_valid  output  1  registered output word valid.
REQ-008 out_data  output  WIDTH  registered output word.
REQ-009 out_sel  output  2  source channel index of out_data (0..3).
REQ-010 out_ready  input  1  downstream accepts out_data at this edge when out_valid is high.

Function
REQ-011 The block SHALL merge four valid/ready channels into one registered output stream, tagging each word with its source index; it is the gathering counterpart of the 1-to-4 demultiplexer.
REQ-012 Slot free SHALL be defined as (!out_valid || out_ready).
REQ-013 Grant SHALL be the first channel with in_valid set, searching cyclically from (last+1) mod 4, where last is a 2-bit registered pointer.
REQ-014 in_ready SHALL be one-hot at the granted channel when slot free and any in_valid set, otherwise all zero; never more than one bit set.
REQ-015 A transfer SHALL occur on an edge where in_valid[g] and in_ready[g] are both high: out_data <= word g, out_sel <= g, out_valid <= 1, last <= g.
REQ-016 Latency SHALL be one cycle: the word accepted at edge N appears on out_data after edge N.
REQ-017 If slot free and no in_valid set, out_valid SHALL go 0 at the edge; out_data, out_sel, last SHALL hold.
REQ-018 If out_valid=1 and out_ready=0 (stall), out_valid, out_data, out_sel, last SHALL hold and in_ready SHALL be 0.
REQ-019 Simultaneous drain and refill (out_valid=1, out_ready=1, any in_valid) SHALL transfer a new word in the same edge with no bubble; full throughput is one word per cycle.
REQ-020 last SHALL update only on a transfer; wrap from 3 to 0 is natural mod-4.
REQ-021 A channel that drops in_valid without a handshake SHALL lose no state; arbitration is re-evaluated every cycle.
REQ-022 With all four channels continuously valid and out_ready=1, grant order SHALL be 0,1,2,3,0,... (no starvation; any valid channel is served within 4 transfers).
REQ-023 Input data width mismatch is not possible; out_data SHALL be a bit-exact copy of the selected in_data slice.

Reset
REQ-024 On rst_n low, immediately and independent of clk: out_valid=0, out_data=0, out_sel=0, last=3 (first grant searches from channel 0).
REQ-025 in_ready SHALL be all zero while rst_n is low.
REQ-026 A word pending in the output register when reset asserts mid-operation SHALL be discarded; the first transfer after release SHALL be on the first clk edge with rst_n high.

Verification
REQ-027 Reset: rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel, in_ready all 0 before next clk edge.
REQ-028 Single channel: in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100, next cycle out_valid=1, out_data=8'hA5, out_sel=2.
REQ-029 Round robin: in_valid=4'b1111, data ch i = 8'h10+i, out_ready=1 for 8 cycles -> out_sel 0,1,2,3,0,1,2,3 with data 8'h10..8'h13 repeating, out_valid continuous.
REQ-030 Stall: out_valid=1 out_sel=1 data 8'h11, out_ready=0 for 3 cycles -> outputs hold, in_ready=4'b0000; out_ready=1 -> next word ch2 accepted same edge.
REQ-031 Skip: last=0, in_valid=4'b1001 -> grant ch3 (in_ready=4'b1000), then ch0.
REQ-032 Drain: in_valid=0, out_ready=1 after one word -> out_valid falls to 0 next cycle, out_data/out_sel hold.

Source files
------------

// File: rtl/rr_mux41.sv
// rr_mux41: four-channel valid/ready round-robin merge into one registered
// output stream. Each output word is tagged with the index of its source
// channel.
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - per-channel word offered
//   in_data    - channel i word in bits [i*WIDTH +: WIDTH]
//   in_ready   - per-channel take strobe (combinational, at most one bit set)
//   out_valid  - registered output word valid
//   out_data   - registered output word
//   out_sel    - source channel index of out_data
//   out_ready  - downstream accepts out_data when out_valid is high
module rr_mux41 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0] last;
  logic [1:0] grant;
  logic       any_valid;
  logic       slot_free;
  logic       xfer;

  assign slot_free = !out_valid || out_ready;

  // Cyclic priority search starting just after the last served channel.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      logic [1:0] idx;
      idx = last + 2'(k + 1);
      if (!any_valid && in_valid[idx]) begin
        grant     = idx;
        any_valid = 1'b1;
      end
    end
  end

  // rst_n gating keeps in_ready low throughout reset, independent of clk.
  always_comb begin
    in_ready = '0;
    if (rst_n && slot_free && any_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign xfer = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= 2'd3;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[grant*WIDTH +: WIDTH];
      out_sel   <= grant;
      last      <= grant;
    end else if (slot_free) begin
      out_valid <= 1'b0;
    end
  end

endmodule
